// File: rtl/m_timer_irq.sv
// Timer-event interrupt controller: decodes timer event codes into pending flags and
// raises a prioritised, acknowledged interrupt with sticky overrun and illegal-code counting.
module m_timer_irq #(
   parameter int WORD  = 8,
   parameter int DWORD = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [DWORD-1:0] instruction,
   input  logic             mask_wr,
   input  logic [5:0]       mask_data,
   input  logic             clear_ovr,
   input  logic             irq_ack,
   output logic             irq,
   output logic [2:0]       irq_vector,
   output logic [5:0]       pending,
   output logic [5:0]       overrun,
   output logic [WORD-1:0]  illegal_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ASSERT   = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   // Codes 1..6 map to one-hot event bits 0..5; anything else maps to nothing.
   function automatic logic [5:0] code_onehot(input logic [2:0] code);
      logic [5:0] oh;
      case (code)
         3'd1:    oh = 6'b000001;
         3'd2:    oh = 6'b000010;
         3'd3:    oh = 6'b000100;
         3'd4:    oh = 6'b001000;
         3'd5:    oh = 6'b010000;
         3'd6:    oh = 6'b100000;
         default: oh = 6'b000000;
      endcase
      return oh;
   endfunction

   // Lowest set index wins; result is index+1, or 0 when nothing is requested.
   function automatic logic [2:0] lowest_vector(input logic [5:0] req);
      logic [2:0] v;
      v = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (req[i]) begin
            v = 3'(i + 1);
         end else begin
            v = v;
         end
      end
      return v;
   endfunction

   state_t          state_r, state_next_s;
   logic            irq_r, irq_next_s;
   logic [2:0]      irq_vector_r, vector_next_s;
   logic [5:0]      pending_r, overrun_r, mask_r;
   logic [WORD-1:0] illegal_cnt_r;

   logic [2:0]      code_s;
   logic [5:0]      evt_set_s, ack_clr_s, eligible_s, ovr_set_s;
   logic            illegal_s;
   logic            unused_upper_s;

   assign code_s         = instruction[2:0];
   assign unused_upper_s = ^instruction[DWORD-1:3];
   assign evt_set_s      = in_valid ? code_onehot(code_s) : 6'b000000;
   assign illegal_s      = in_valid && ((code_s == 3'd0) || (code_s == 3'd7));
   assign eligible_s     = pending_r & ~mask_r;
   // A new event on the bit being acknowledged re-arms it rather than counting as overrun.
   assign ovr_set_s      = evt_set_s & pending_r & ~ack_clr_s;

   // Next-state and next-output logic of the service FSM.
   always_comb begin
      state_next_s  = state_r;
      irq_next_s    = irq_r;
      vector_next_s = irq_vector_r;
      ack_clr_s     = 6'b000000;
      case (state_r)
         IDLE: begin
            if (eligible_s != 6'b000000) begin
               state_next_s  = ASSERT;
               irq_next_s    = 1'b1;
               vector_next_s = lowest_vector(eligible_s);
            end else begin
               state_next_s  = IDLE;
               irq_next_s    = 1'b0;
               vector_next_s = 3'd0;
            end
         end
         ASSERT: begin
            if (irq_ack) begin
               ack_clr_s     = code_onehot(irq_vector_r);
               state_next_s  = WAIT_REL;
               irq_next_s    = 1'b0;
               vector_next_s = 3'd0;
            end else begin
               state_next_s  = ASSERT;
               irq_next_s    = irq_r;
               vector_next_s = irq_vector_r;
            end
         end
         WAIT_REL: begin
            if (!irq_ack) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WAIT_REL;
            end
         end
         default: begin
            state_next_s  = IDLE;
            irq_next_s    = 1'b0;
            vector_next_s = 3'd0;
         end
      endcase
   end

   // All state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         irq_r         <= 1'b0;
         irq_vector_r  <= 3'd0;
         pending_r     <= 6'b000000;
         overrun_r     <= 6'b000000;
         mask_r        <= 6'b000000;
         illegal_cnt_r <= {WORD{1'b0}};
      end else begin
         state_r      <= state_next_s;
         irq_r        <= irq_next_s;
         irq_vector_r <= vector_next_s;
         pending_r    <= (pending_r & ~ack_clr_s) | evt_set_s;
         overrun_r    <= (clear_ovr ? 6'b000000 : overrun_r) | ovr_set_s;
         if (mask_wr) begin
            mask_r <= mask_data;
         end
         if (illegal_s && (illegal_cnt_r != {WORD{1'b1}})) begin
            illegal_cnt_r <= illegal_cnt_r + {{(WORD-1){1'b0}}, 1'b1};
         end
      end
   end

   assign irq         = irq_r;
   assign irq_vector  = irq_vector_r;
   assign pending     = pending_r;
   assign overrun     = overrun_r;
   assign illegal_cnt = illegal_cnt_r;

endmodule
